keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with per-key debounce.
// Rows are driven one-hot active-low; a closed key pulls its column low.
// One key is tracked at a time: once a column is latched, all other
// columns are ignored until that key has been released and debounced.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);
  localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE - 1);

  state_t     state_q;
  logic [1:0] row_idx_q;
  logic [1:0] col_idx_q;
  logic [7:0] dwell_q;
  logic [7:0] cnt_q;
  logic [3:0] row_q;
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       key_held_q;

  logic [1:0] first_low_d;
  logic       key_up_d;
  logic [1:0] next_row_d;

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : 8'(v + 8'd1);
  endfunction

  // Lowest-numbered low column wins; level of the tracked column; next row index.
  always_comb begin
    first_low_d = 2'd0;
    if (!col[0])      first_low_d = 2'd0;
    else if (!col[1]) first_low_d = 2'd1;
    else if (!col[2]) first_low_d = 2'd2;
    else if (!col[3]) first_low_d = 2'd3;
    key_up_d   = col[col_idx_q];
    next_row_d = 2'(row_idx_q + 2'd1);
  end

  // Scan/debounce FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SCAN;
      row_idx_q   <= 2'd0;
      col_idx_q   <= 2'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      row_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        S_SCAN: begin
          if (dwell_q >= DWELL_LAST) begin
            if (&col) begin
              row_idx_q <= next_row_d;
              row_q     <= row_drive(next_row_d);
              dwell_q   <= '0;
            end else begin
              col_idx_q <= first_low_d;
              cnt_q     <= '0;
              state_q   <= S_DEBOUNCE;
            end
          end else begin
            dwell_q <= sat_inc(dwell_q);
          end
        end
        S_DEBOUNCE: begin
          if (key_up_d) begin
            row_idx_q <= next_row_d;
            row_q     <= row_drive(next_row_d);
            dwell_q   <= '0;
            cnt_q     <= '0;
            state_q   <= S_SCAN;
          end else if (cnt_q >= DB_LAST) begin
            // The clock that would make the count reach DEBOUNCE accepts the key.
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            key_code_q  <= {row_idx_q, col_idx_q};
            state_q     <= S_HELD;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        S_HELD: begin
          if (key_up_d) begin
            cnt_q   <= 8'd1;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!key_up_d) begin
            state_q <= S_HELD;
          end else if (cnt_q >= DB_LAST) begin
            row_idx_q  <= next_row_d;
            row_q      <= row_drive(next_row_d);
            dwell_q    <= '0;
            cnt_q      <= '0;
            key_held_q <= 1'b0;
            state_q    <= S_SCAN;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: state_q <= S_SCAN;
      endcase
    end
  end

  assign row       = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
